uart_rx: RTL and testbench

- Serial receiver for the host command link: accepts 8N1 asynchronous frames on `rx`, LSB first.
- Presents each byte to the processor through a single-entry holding register with a valid/read handshake.
- Counterpart of the team's UART transmitter. Sits between the FPGA pin and the processor's memory-mapped I/O read path.
- Reports framing and overrun errors as sticky flags.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants, parity helper.
// Used by both the receiver (uart_rx) and the transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned STATE_W          = 3;

    // Fixed encoding so both directions decode the same values in debug views
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4,
        PARITY    = 3'd5
    } state_t;

    // Even parity: data bits plus parity bit must contain an even number of ones
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin. Both flops preset to 1
// (line idle) on clr so reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: d -> meta -> q
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with single-entry holding register and sticky error flags.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN,
// which adds a PARITY state and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rx,
    input  logic                 rd_en,
    input  logic                 err_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_c;
    logic                 frame_set_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_set_c;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .clr (clr),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic; the timer restarts on every state change so it never wraps
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver_c   = 1'b0;
        frame_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_set_c   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    if (!even_parity_ok(shift_q, rx_s)) begin
                        par_set_c = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d   = IDLE;
`ifdef UART_RX_PARITY_EN
                        deliver_c = !par_bad_q;
`else
                        deliver_c = 1'b1;
`endif
                    end else begin
                        frame_set_c = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Hold off re-arming until a break condition releases the line
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Holding register, read handshake, sticky flags and busy
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            busy <= (state_d != IDLE);

            if (deliver_c && (!valid || rd_en)) begin
                data_out <= shift_q;
                valid    <= 1'b1;
            end else if (rd_en && valid) begin
                valid <= 1'b0;
            end

            // A new error in the same cycle as err_ack takes priority
            if (deliver_c && valid && !rd_en) begin
                overrun <= 1'b1;
            end else if (err_ack) begin
                overrun <= 1'b0;
            end

            if (frame_set_c) begin
                frame_err <= 1'b1;
            end else if (err_ack) begin
                frame_err <= 1'b0;
            end

`ifdef UART_RX_PARITY_EN
            if (par_set_c) begin
                parity_err <= 1'b1;
            end else if (err_ack) begin
                parity_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=16.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Cycle index (within a frame) whose clock edge samples the stop bit
    localparam int STOP_CYC = 2 + CPB / 2 + (NB - 1) * CPB;
    localparam int LAT_NOM  = 2 + CPB / 2 + (NB - 1) * CPB;

    logic       clk = 1'b0;
    logic       clr;
    logic       rx;
    logic       rd_en;
    logic       err_ack;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks      = 0;
    int failures    = 0;
    int valid_cycle = -1;
    int valid_rises = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk        (clk),
        .clr        (clr),
        .rx         (rx),
        .rd_en      (rd_en),
        .err_ack    (err_ack),
        .data_out   (data_out),
        .valid      (valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_read();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic pulse_ack();
        err_ack = 1'b1;
        @(posedge clk);
        #1;
        err_ack = 1'b0;
    endtask

    // Drive one frame on rx; optionally pulse rd_en in cycle rd_cycle
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_bit, input int rd_cycle);
        logic [10:0] bits;
        logic        prev;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, par_bit, b, 1'b0};
`else
        bits = {1'b0, stop_bit, b, 1'b0};
`endif
        valid_cycle = -1;
        valid_rises = 0;
        prev = valid;
        for (int c = 0; c < NB * CPB; c++) begin
            rx    = bits[c / CPB];
            rd_en = (c == rd_cycle);
            @(posedge clk);
            #1;
            if (valid && !prev) begin
                valid_rises++;
                if (valid_cycle < 0) valid_cycle = c + 1;
            end
            prev = valid;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; rx = 1'b1; rd_en = 1'b0; err_ack = 1'b0;
        idle(3);
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {frame_err, overrun}); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        clr = 1'b0;
        idle(4);
    endtask

    task automatic test_clean_frame();
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL clean_valid got=%b exp=1", valid); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL clean_data got=%h exp=a5", data_out); end
        checks++; if ({frame_err, overrun} !== 2'b00) begin failures++; $display("FAIL clean_flags got=%b exp=00", {frame_err, overrun}); end
        checks++; if (valid_rises !== 1) begin failures++; $display("FAIL clean_rises got=%0d exp=1", valid_rises); end
        checks++;
        if (valid_cycle < LAT_NOM - 1 || valid_cycle > LAT_NOM + 1) begin
            failures++; $display("FAIL clean_latency got=%0d exp=%0d+-1", valid_cycle, LAT_NOM);
        end
        pulse_read();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL read_valid got=%b exp=0", valid); end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL read_hold got=%h exp=a5", data_out); end
        pulse_read();
        checks++; if ({valid, data_out} !== {1'b0, 8'hA5}) begin failures++; $display("FAIL read_empty got=%b/%h exp=0/a5", valid, data_out); end
    endtask

    task automatic test_glitch();
        int  n;
        logic saw_busy;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        n = 0;
        while (n < 8 && busy !== 1'b0) begin
            @(posedge clk); #1;
            saw_busy = 1'b1;
            n++;
        end
        checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_drop got=%b exp=0", busy); end
        checks++; if ({valid, frame_err, overrun} !== 3'b000) begin failures++; $display("FAIL glitch_state got=%b exp=000", {valid, frame_err, overrun}); end
        idle(4);
    endtask

    task automatic test_frame_error();
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rx = 1'b0;
        idle(40);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ferr_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_hold got=%b exp=1", busy); end
        rx = 1'b1;
        idle(6);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
        send_frame(8'h55, 1'b1, 1'b0, -1);
        checks++; if ({valid, data_out} !== {1'b1, 8'h55}) begin failures++; $display("FAIL ferr_next got=%b/%h exp=1/55", valid, data_out); end
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_sticky got=%b exp=1", frame_err); end
        pulse_ack();
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_ack got=%b exp=0", frame_err); end
        pulse_read();
        idle(4);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        checks++; if (data_out !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", data_out); end
        checks++; if ({valid, overrun} !== 2'b11) begin failures++; $display("FAIL ovr_flags got=%b exp=11", {valid, overrun}); end
        pulse_ack();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_ack got=%b exp=0", overrun); end
        pulse_read();
        idle(4);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, STOP_CYC);
        checks++; if (data_out !== 8'h22) begin failures++; $display("FAIL b2b_read_data got=%h exp=22", data_out); end
        checks++; if ({valid, overrun} !== 2'b10) begin failures++; $display("FAIL b2b_read_flags got=%b exp=10", {valid, overrun}); end
        idle(4);
    endtask

    task automatic test_clr_abort();
        logic [10:0] bits;
        bits = {3'b111, 8'hFF};
        bits[0] = 1'b0;
        for (int c = 0; c < NB * CPB; c++) begin
            rx  = bits[c / CPB];
            clr = 1'b0;
            if (c == 5 * CPB + CPB / 2) begin
                clr = 1'b1;
                #1;
                checks++; if ({data_out, valid, frame_err, overrun, busy} !== 12'h000) begin
                    failures++; $display("FAIL clr_async got=%h/%b%b%b%b exp=00/0000", data_out, valid, frame_err, overrun, busy);
                end
            end
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        rx  = 1'b1;
        idle(4);
        checks++; if ({valid, busy} !== 2'b00) begin failures++; $display("FAIL clr_no_partial got=%b exp=00", {valid, busy}); end
        send_frame(8'h81, 1'b1, 1'b0, -1);
        checks++; if ({valid, data_out} !== {1'b1, 8'h81}) begin failures++; $display("FAIL clr_next got=%b/%h exp=1/81", valid, data_out); end
        pulse_read();
        idle(4);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b0, -1);
        checks++; if (parity_err !== 1'b1) begin failures++; $display("FAIL par_bad_flag got=%b exp=1", parity_err); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL par_bad_valid got=%b exp=0", valid); end
        pulse_ack();
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_ack got=%b exp=0", parity_err); end
        send_frame(8'h07, 1'b1, 1'b1, -1);
        checks++; if ({valid, data_out} !== {1'b1, 8'h07}) begin failures++; $display("FAIL par_good got=%b/%h exp=1/07", valid, data_out); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL par_good_flag got=%b exp=0", parity_err); end
        pulse_read();
    endtask
`endif

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_clr_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
